// File: rtl/fox_packet_bridge_if.sv
// -----------------------------------------------------------------------------
// fox_packet_bridge_if
//   Bundles every non-clock, non-reset signal of fox_packet_bridge: the core's
//   per-field write port, the core's read port for received packets, the
//   router-side TX/RX handshakes, and the sticky error flags.
//
//   Modports
//     slave  : the bridge itself (consumes field writes and router packets,
//              drives packet_out, RX head fields, ready/valid flags, errors)
//     master : the environment around the bridge (processing core + router)
//
//   Packet layout (MSB..LSB):
//     x, y, multicast_group, done, result, matrix_type, matrix_x, matrix_y,
//     matrix_element
// -----------------------------------------------------------------------------
interface fox_packet_bridge_if #(
  parameter int COORD_BITS           = 1,
  parameter int MULTICAST_GROUP_BITS = 1,
  parameter int MATRIX_TYPE_BITS     = 1,
  parameter int MATRIX_COORD_BITS    = 8,
  parameter int MATRIX_ELEMENT_BITS  = 32
);
  localparam int PW = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 + MATRIX_TYPE_BITS
                    + 2*MATRIX_COORD_BITS + MATRIX_ELEMENT_BITS;

  // core -> bridge field writes
  logic [COORD_BITS-1:0]           x_coord_in;
  logic                            x_coord_in_valid;
  logic [COORD_BITS-1:0]           y_coord_in;
  logic                            y_coord_in_valid;
  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_in;
  logic                            multicast_group_in_valid;
  logic                            done_flag_in;
  logic                            done_flag_in_valid;
  logic                            result_flag_in;
  logic                            result_flag_in_valid;
  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_in;
  logic                            matrix_type_in_valid;
  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_in;
  logic                            matrix_x_coord_in_valid;
  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_in;
  logic                            matrix_y_coord_in_valid;
  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_in;
  logic                            matrix_element_in_valid;
  logic                            packet_complete_in;
  logic                            message_out_ready;

  // bridge -> router
  logic [PW-1:0]                   packet_out;
  logic                            packet_out_valid;
  logic                            packet_out_ready;

  // router -> bridge
  logic [PW-1:0]                   packet_in;
  logic                            packet_in_valid;
  logic                            packet_in_ready;

  // bridge -> core, head of the receive queue
  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_out;
  logic                            done_flag_out;
  logic                            result_flag_out;
  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_out;
  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_out;
  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_out;
  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_out;
  logic                            message_in_available;
  logic                            message_in_valid;
  logic                            message_in_read;

  // sticky error flags
  logic                            tx_overflow;
  logic                            rx_underflow;

  modport slave (
    input  x_coord_in, x_coord_in_valid, y_coord_in, y_coord_in_valid,
           multicast_group_in, multicast_group_in_valid,
           done_flag_in, done_flag_in_valid, result_flag_in, result_flag_in_valid,
           matrix_type_in, matrix_type_in_valid,
           matrix_x_coord_in, matrix_x_coord_in_valid,
           matrix_y_coord_in, matrix_y_coord_in_valid,
           matrix_element_in, matrix_element_in_valid,
           packet_complete_in, packet_out_ready,
           packet_in, packet_in_valid, message_in_read,
    output message_out_ready, packet_out, packet_out_valid, packet_in_ready,
           multicast_group_out, done_flag_out, result_flag_out, matrix_type_out,
           matrix_x_coord_out, matrix_y_coord_out, matrix_element_out,
           message_in_available, message_in_valid, tx_overflow, rx_underflow
  );

  modport master (
    output x_coord_in, x_coord_in_valid, y_coord_in, y_coord_in_valid,
           multicast_group_in, multicast_group_in_valid,
           done_flag_in, done_flag_in_valid, result_flag_in, result_flag_in_valid,
           matrix_type_in, matrix_type_in_valid,
           matrix_x_coord_in, matrix_x_coord_in_valid,
           matrix_y_coord_in, matrix_y_coord_in_valid,
           matrix_element_in, matrix_element_in_valid,
           packet_complete_in, packet_out_ready,
           packet_in, packet_in_valid, message_in_read,
    input  message_out_ready, packet_out, packet_out_valid, packet_in_ready,
           multicast_group_out, done_flag_out, result_flag_out, matrix_type_out,
           matrix_x_coord_out, matrix_y_coord_out, matrix_element_out,
           message_in_available, message_in_valid, tx_overflow, rx_underflow
  );
endinterface

// File: rtl/fox_packet_bridge.sv
// -----------------------------------------------------------------------------
// fox_packet_bridge
//   Network-side endpoint of a processing node's memory-mapped message port.
//   TX: the core writes packet fields one strobe at a time; packet_complete_in
//       snapshots the fields into a packet and queues it for the Hoplite router.
//   RX: packets offered by the router are queued; the head packet is shown to
//       the core as separate fields and is popped by message_in_read.
//
//   Ports
//     clk      : clock
//     reset_n  : active-low reset, asserted asynchronously, released
//                synchronously through an internal two-stage synchroniser
//     bus      : fox_packet_bridge_if.slave (field writes, router TX/RX
//                handshakes, RX head fields, sticky error flags)
// -----------------------------------------------------------------------------

// Small first-word-fall-through FIFO used for both directions. The head entry
// is always visible on rdata; full/empty come from the registered count only.
module fox_packet_bridge_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         push_ok,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          pop_ok;

  assign empty  = (count_reg == '0);
  assign full   = (count_reg == CW'(DEPTH));
  assign pop_ok = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle:
  // the write lands in the slot being vacated.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // DEPTH is a power of two, so plain pointer increments wrap correctly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

module fox_packet_bridge #(
  parameter int COORD_BITS           = 1,
  parameter int MULTICAST_GROUP_BITS = 1,
  parameter int MATRIX_TYPE_BITS     = 1,
  parameter int MATRIX_COORD_BITS    = 8,
  parameter int MATRIX_ELEMENT_BITS  = 32,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  fox_packet_bridge_if.slave  bus
);
  localparam int PW = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 + MATRIX_TYPE_BITS
                    + 2*MATRIX_COORD_BITS + MATRIX_ELEMENT_BITS;

  // Bit offsets of each field inside a packet, counted from the LSB.
  localparam int ELEM_LSB = 0;
  localparam int MY_LSB   = ELEM_LSB + MATRIX_ELEMENT_BITS;
  localparam int MX_LSB   = MY_LSB + MATRIX_COORD_BITS;
  localparam int TYPE_LSB = MX_LSB + MATRIX_COORD_BITS;
  localparam int RES_LSB  = TYPE_LSB + MATRIX_TYPE_BITS;
  localparam int DONE_LSB = RES_LSB + 1;
  localparam int MG_LSB   = DONE_LSB + 1;
  localparam int Y_LSB    = MG_LSB + MULTICAST_GROUP_BITS;

  localparam int SYNC_STAGES = 2;

  // ---------------------------------------------------------------------------
  // Reset synchroniser: reset_n clears every stage at once, release ripples
  // through SYNC_STAGES clock edges so no flop sees a release near an edge.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] rst_sync_reg;
  logic                   rst_n;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_rst_sync
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rst_sync_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          rst_sync_reg[gi] <= 1'b1;
        end else begin
          rst_sync_reg[gi] <= rst_sync_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign rst_n = rst_sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Field registers: each holds its last written value; a complete does not
  // clear them, so repeated completes resend the same packet.
  // ---------------------------------------------------------------------------
  logic [COORD_BITS-1:0]           x_coord_reg;
  logic [COORD_BITS-1:0]           y_coord_reg;
  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_reg;
  logic                            done_flag_reg;
  logic                            result_flag_reg;
  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_reg;
  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_reg;
  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_reg;
  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_coord_reg         <= '0;
      y_coord_reg         <= '0;
      multicast_group_reg <= '0;
      done_flag_reg       <= 1'b0;
      result_flag_reg     <= 1'b0;
      matrix_type_reg     <= '0;
      matrix_x_coord_reg  <= '0;
      matrix_y_coord_reg  <= '0;
      matrix_element_reg  <= '0;
    end else begin
      if (bus.x_coord_in_valid)         x_coord_reg         <= bus.x_coord_in;
      if (bus.y_coord_in_valid)         y_coord_reg         <= bus.y_coord_in;
      if (bus.multicast_group_in_valid) multicast_group_reg <= bus.multicast_group_in;
      if (bus.done_flag_in_valid)       done_flag_reg       <= bus.done_flag_in;
      if (bus.result_flag_in_valid)     result_flag_reg     <= bus.result_flag_in;
      if (bus.matrix_type_in_valid)     matrix_type_reg     <= bus.matrix_type_in;
      if (bus.matrix_x_coord_in_valid)  matrix_x_coord_reg  <= bus.matrix_x_coord_in;
      if (bus.matrix_y_coord_in_valid)  matrix_y_coord_reg  <= bus.matrix_y_coord_in;
      if (bus.matrix_element_in_valid)  matrix_element_reg  <= bus.matrix_element_in;
    end
  end

  // A strobe landing in the same cycle as packet_complete_in must already be
  // part of the packet, so every field bypasses its register when strobed.
  logic [PW-1:0] tx_packet;

  assign tx_packet = {
    bus.x_coord_in_valid         ? bus.x_coord_in         : x_coord_reg,
    bus.y_coord_in_valid         ? bus.y_coord_in         : y_coord_reg,
    bus.multicast_group_in_valid ? bus.multicast_group_in : multicast_group_reg,
    bus.done_flag_in_valid       ? bus.done_flag_in       : done_flag_reg,
    bus.result_flag_in_valid     ? bus.result_flag_in     : result_flag_reg,
    bus.matrix_type_in_valid     ? bus.matrix_type_in     : matrix_type_reg,
    bus.matrix_x_coord_in_valid  ? bus.matrix_x_coord_in  : matrix_x_coord_reg,
    bus.matrix_y_coord_in_valid  ? bus.matrix_y_coord_in  : matrix_y_coord_reg,
    bus.matrix_element_in_valid  ? bus.matrix_element_in  : matrix_element_reg
  };

  // ---------------------------------------------------------------------------
  // TX queue (core -> router)
  // ---------------------------------------------------------------------------
  logic tx_push_ok;
  logic tx_full;
  logic tx_empty;
  logic tx_pop;

  assign tx_pop = !tx_empty && bus.packet_out_ready;

  fox_packet_bridge_fifo #(
    .W     (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (bus.packet_complete_in),
    .wdata   (tx_packet),
    .pop     (tx_pop),
    .rdata   (bus.packet_out),
    .push_ok (tx_push_ok),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  assign bus.packet_out_valid  = !tx_empty;
  assign bus.message_out_ready = !tx_full;

  // ---------------------------------------------------------------------------
  // RX queue (router -> core). The router only transfers on valid && ready,
  // and ready depends solely on the registered count.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] rx_head;
  logic          rx_push_ok;
  logic          rx_full;
  logic          rx_empty;

  fox_packet_bridge_fifo #(
    .W     (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (bus.packet_in_valid && !rx_full),
    .wdata   (bus.packet_in),
    .pop     (bus.message_in_read),
    .rdata   (rx_head),
    .push_ok (rx_push_ok),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  assign bus.packet_in_ready      = !rx_full;
  assign bus.message_in_available = !rx_empty;
  assign bus.message_in_valid     = !rx_empty;

  assign bus.multicast_group_out = rx_head[MG_LSB   +: MULTICAST_GROUP_BITS];
  assign bus.done_flag_out       = rx_head[DONE_LSB];
  assign bus.result_flag_out     = rx_head[RES_LSB];
  assign bus.matrix_type_out     = rx_head[TYPE_LSB +: MATRIX_TYPE_BITS];
  assign bus.matrix_x_coord_out  = rx_head[MX_LSB   +: MATRIX_COORD_BITS];
  assign bus.matrix_y_coord_out  = rx_head[MY_LSB   +: MATRIX_COORD_BITS];
  assign bus.matrix_element_out  = rx_head[ELEM_LSB +: MATRIX_ELEMENT_BITS];

  // Destination x/y only matter to the router; the core never sees them, and
  // the RX push handshake is fully described by valid/ready.
  logic unused_rx_bits;
  assign unused_rx_bits = ^rx_head[PW-1:Y_LSB] ^ rx_push_ok;

  // ---------------------------------------------------------------------------
  // Sticky error flags, cleared only by reset.
  // ---------------------------------------------------------------------------
  logic tx_overflow_reg;
  logic rx_underflow_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_overflow_reg  <= 1'b0;
      rx_underflow_reg <= 1'b0;
    end else begin
      if (bus.packet_complete_in && !tx_push_ok) begin
        tx_overflow_reg <= 1'b1;
      end
      if (bus.message_in_read && rx_empty) begin
        rx_underflow_reg <= 1'b1;
      end
    end
  end

  assign bus.tx_overflow  = tx_overflow_reg;
  assign bus.rx_underflow = rx_underflow_reg;
endmodule
